// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - state_t : arbiter FSM encoding (IDLE / EXEC / RESP)
//   - ALUC_*  : ALU opcode constants
//   - DW      : operand / result width
package alu_arb_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU.
//   a, b  : operands (shifts move b by a[4:0]; LUI places b[15:0] in the upper half)
//   aluc  : opcode; undefined codes produce s = 0
//   s, z  : result and zero flag
module alu
    import alu_arb_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    aluc,
    output logic [DW-1:0] s,
    output logic          z
);

    always_comb begin
        s = '0;
        case (aluc)
            ALUC_ADD: s = a + b;
            ALUC_SUB: s = a - b;
            ALUC_AND: s = a & b;
            ALUC_OR:  s = a | b;
            ALUC_XOR: s = a ^ b;
            ALUC_LUI: s = {b[15:0], 16'h0000};
            ALUC_SLL: s = b << a[4:0];
            ALUC_SRL: s = b >> a[4:0];
            ALUC_SRA: s = $unsigned($signed(b) >>> a[4:0]);
            default:  s = '0;
        endcase
    end

    assign z = (s == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req  : request vector
//   i_last : index of the most recent grant; search starts at i_last+1
//   o_gnt  : one-hot grant (zero when no request)
//   o_idx  : encoded index of the grant
//   o_any  : at least one request present
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        int c;
        c     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            // i_last < NREQ, so one subtraction wraps the candidate
            c = int'(i_last) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!o_any && i_req[c]) begin
                o_any    = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
//   clock, resetn      : clock, async active-low reset
//   req_valid/req_ready: per-requester handshake (req_ready is a one-hot grant)
//   req_a/req_b/aluc   : packed per-requester operands and opcode
//   rsp_valid/rsp_ready: response handshake
//   rsp_id/rsp_s/rsp_z : owner index, ALU result, zero flag
//   busy               : FSM not idle
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [DW*NREQ-1:0]   req_a,
    input  logic [DW*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_aluc,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_s,
    output logic                 rsp_z,
    output logic                 busy
);

    state_t          r_state;
    logic [IDW-1:0]  r_last;
    logic [DW-1:0]   r_a, r_b;
    logic [3:0]      r_aluc;
    logic [IDW-1:0]  r_id;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_s;
    logic            r_rsp_z;
    logic [IDW-1:0]  r_rsp_id;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_take;
    logic            w_fire;
    logic [DW-1:0]   w_a, w_b, w_s;
    logic [3:0]      w_aluc;
    logic            w_z;

    rr_arbiter #(.NREQ(NREQ), .IW(IDW)) u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // A grant slot opens in IDLE, or in RESP on the same cycle the consumer
    // takes the response. Reset forces req_ready low immediately.
    assign w_take    = resetn && ((r_state == ST_IDLE) ||
                                  (r_state == ST_RESP && rsp_ready));
    assign w_fire    = w_take && w_any;
    assign req_ready = w_take ? w_gnt : '0;

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_aluc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a    = req_a[i*DW +: DW];
                w_b    = req_b[i*DW +: DW];
                w_aluc = req_aluc[i*4 +: 4];
            end
        end
    end

    alu u_alu (
        .a    (r_a),
        .b    (r_b),
        .aluc (r_aluc),
        .s    (w_s),
        .z    (w_z)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_a         <= '0;
            r_b         <= '0;
            r_aluc      <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            // w_fire can only be true in IDLE or in an acknowledged RESP
            if (w_fire) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_aluc <= w_aluc;
                r_id   <= w_idx;
                r_last <= w_idx;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_rsp_s     <= w_s;
                    r_rsp_z     <= w_z;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_fire ? ST_EXEC : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_s     = r_rsp_s;
    assign rsp_z     = r_rsp_z;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's 32-bit combinational `alu` between `NREQ` independent requesters, for example a fetch-side address adder and an execute-side datapath. Requests are granted round-robin. The chosen operands are captured into an operand register, evaluated by the ALU in the next cycle, and returned on a single tagged response channel with valid/ready backpressure. The block sits between requesting pipeline stages and the shared ALU.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `IDW`, default 2: response tag width; must satisfy `IDW >= clog2(NREQ)`.

Ports:
- `clock` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester request strobe.
- `req_ready` out NREQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_a` in 32*NREQ: operand a; requester i occupies bits [32i+31:32i].
- `req_b` in 32*NREQ: operand b, packed the same way.
- `req_aluc` in 4*NREQ: ALU opcode; requester i occupies bits [4i+3:4i].
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_s` out 32: ALU result.
- `rsp_z` out 1: zero flag of `rsp_s`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, assert `req_ready` for the round-robin winner only.
  - Capture that requester's a, b, aluc and index into the operand register, then go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - The ALU evaluates the operand register.
  - `s` and `z` are registered into `rsp_s` and `rsp_z`, the index goes to `rsp_id`, `rsp_valid` is set, and the FSM goes to RESP.
- **RESP**
  - `rsp_valid` stays high and `rsp_s`, `rsp_z`, `rsp_id` stay stable until `rsp_ready` is sampled high.
  - If `rsp_ready` is high and some `req_valid` is high: grant the next winner in this same cycle, capture its operands, and go to EXEC. The consumer's acknowledge and the new grant happen together.
  - If `rsp_ready` is high and no request is valid: go to IDLE.
  - If `rsp_ready` is low: stay in RESP and keep `req_ready` all zero.
- **Round-robin**
  - The pointer `last` holds the index of the most recent grant.
  - Search order is `last+1, last+2, …` modulo NREQ.
  - `last` updates only on a grant.
- `req_ready` is a combinational function of state, `req_valid` and `last`. Requesters must not make `req_valid` depend on `req_ready`.
- Requesters hold `req_valid` and payload stable until granted. Dropping `req_valid` before the grant is legal and simply withdraws the request.
- Opcodes are passed through to the ALU unchanged. An undefined aluc (for example 4'b1011) returns `s = 0` and `z = 1`; this is not an error.
- Shift opcodes use `a[4:0]` as the shift amount, as the ALU does.

## Timing
- Reset values: state IDLE, `last = NREQ-1` (so requester 0 wins first), `rsp_valid = 0`, `rsp_s = 0`, `rsp_z = 0`, `rsp_id = 0`, operand register 0, `req_ready = 0`, `busy = 0`.
- Latency: `rsp_valid` rises 2 clock edges after the grant edge.
- Throughput: one operation every 2 cycles when `rsp_ready` is held high.
- If `resetn` is asserted in EXEC or RESP, the in-flight operation is discarded and no response is issued. Outputs reach their reset values immediately.
- If `rsp_ready` is high while `rsp_valid` is low, it is ignored.
- If all requesters are valid continuously, the grant order for NREQ=2 is 0,1,0,1,…; no requester waits for more than NREQ−1 other grants.

## Structure
- Package `alu_arb_pkg` contains:
  - the state encoding (IDLE/EXEC/RESP);
  - named aluc constants: ADD 4'b0000, SUB 4'b0100, AND 4'b0001, OR 4'b0101, XOR 4'b0010, LUI 4'b0110, SLL 4'b0011, SRL 4'b0111, SRA 4'b1111;
  - the operand width constant, 32.
- Sub-module `rr_arbiter`: combinational round-robin picker. It takes the request vector and `last` and produces a one-hot grant plus the encoded index.
- The existing `alu` is instantiated once, unmodified.

## Test plan
- **Reset, then single request.** Requester 0 sends a=5, b=7, aluc=ADD. Expected: `req_ready[0]` high in the same cycle; 2 cycles later `rsp_valid = 1`, `rsp_s = 12`, `rsp_z = 0`, `rsp_id = 0`.
- **Contention.** Both requesters valid from reset: requester 0 with a=9, b=9, SUB; requester 1 with a=4, b=0xF0F0, SLL. `rsp_ready` held high. Expected:
  - first response: `rsp_id = 0`, `rsp_s = 0`, `rsp_z = 1`;
  - second response, 2 cycles later: `rsp_id = 1`, `rsp_s = 0x000F0F00`;
  - grants keep alternating after that.
- **Backpressure.** Hold `rsp_ready = 0` for 5 cycles while requester 1 stays valid. Expected: `rsp_s`, `rsp_z`, `rsp_id` stable; `req_ready` all zero. When `rsp_ready` rises, requester 1 is granted in that same cycle.
- **SRA and undefined opcode.**
  - b=0x80000000, a=4, aluc=4'b1111 gives `rsp_s = 0xF8000000`.
  - aluc=4'b1011 gives `rsp_s = 0`, `rsp_z = 1`.
- **Reset mid-operation.** Assert `resetn` low during EXEC. Expected: no response ever appears for that request; all outputs return to reset values; after release, requester 0 has priority.
- **Withdrawn request.** Requester 1 drops `req_valid` while RESP is stalled. Expected: it is never granted and no spurious response appears.
